// File: rtl/multi.sv
// multi: sequential signed 32x32 -> 64 multiplier, radix-2 shift-add,
// sign-magnitude datapath, one operation in flight.
//
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous, active-low reset
//   mlier  - multiplier (signed), sampled on the load edge only
//   mcand  - multiplicand (signed), sampled on the load edge only
//   start  - level request, held by the requester until valid is seen
//   prodt  - registered 64-bit signed product, held until next result/reset
//   valid  - one-cycle pulse marking a new prodt
//
// Build option: define MULTI_VAR_LATENCY_EN for data-dependent early
// termination (K = max(1, bit-length of |mlier|)); otherwise K = 32.
module multi (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] mlier,
    input  logic [31:0] mcand,
    input  logic        start,
    output logic [63:0] prodt,
    output logic        valid
);

    localparam int unsigned W  = 32;
    localparam int unsigned PW = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [W-1:0]    mplr;      // remaining multiplier magnitude, shifted right
    logic [PW-1:0]   mcd;       // multiplicand magnitude, shifted left
    logic [PW-1:0]   acc;       // accumulated product magnitude
    logic            sign;

`ifndef MULTI_VAR_LATENCY_EN
    logic [4:0]      cnt;       // iteration index 0..31
`endif

    logic [W-1:0]    mlier_mag;
    logic [W-1:0]    mcand_mag;
    logic [PW-1:0]   acc_sum;
    logic            last;

    // Operand magnitudes; 0x80000000 negates to itself, i.e. 2^31 unsigned.
    always_comb begin
        mlier_mag = mlier[W-1] ? W'(-mlier) : mlier;
        mcand_mag = mcand[W-1] ? W'(-mcand) : mcand;
    end

    // One shift-add step and the end-of-loop condition.
    always_comb begin
        acc_sum = acc + (mplr[0] ? mcd : '0);
`ifdef MULTI_VAR_LATENCY_EN
        last    = (mplr[W-1:1] == '0);
`else
        last    = (cnt == 5'd31);
`endif
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            mplr  <= '0;
            mcd   <= '0;
            acc   <= '0;
            sign  <= 1'b0;
            prodt <= '0;
            valid <= 1'b0;
`ifndef MULTI_VAR_LATENCY_EN
            cnt   <= '0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mplr  <= mlier_mag;
                        mcd   <= PW'(mcand_mag);
                        acc   <= '0;
                        sign  <= mlier[W-1] ^ mcand[W-1];
`ifndef MULTI_VAR_LATENCY_EN
                        cnt   <= '0;
`endif
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    acc  <= acc_sum;
                    mplr <= mplr >> 1;
                    mcd  <= mcd << 1;
`ifndef MULTI_VAR_LATENCY_EN
                    cnt  <= cnt + 5'd1;
`endif
                    if (last) begin
                        // Negating a zero magnitude yields zero, so no -0.
                        prodt <= sign ? PW'(-acc_sum) : acc_sum;
                        valid <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Wait for the requester to drop start before rearming.
                    if (!start) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi.sv
// tb_multi: randomized self-checking bench for multi against a plain
// arithmetic reference (signed product and bit-length latency).
module tb_multi;

    logic        clock;
    logic        reset;
    logic [31:0] mlier;
    logic [31:0] mcand;
    logic        start;
    logic [63:0] prodt;
    logic        valid;

    int n_cmp = 0;
    int n_err = 0;

    multi dut (
        .clock (clock),
        .reset (reset),
        .mlier (mlier),
        .mcand (mcand),
        .start (start),
        .prodt (prodt),
        .valid (valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return 64'(p);
    endfunction

    function automatic int ref_lat(input logic [31:0] a);
`ifdef MULTI_VAR_LATENCY_EN
        longint m;
        int     k;
        m = longint'($signed(a));
        if (m < 0) m = -m;
        k = 0;
        while (m != 0) begin
            m = m / 2;
            k++;
        end
        return (k < 1) ? 1 : k;
`else
        return (a === 32'hx) ? 0 : 32;
`endif
    endfunction

    // One full transaction: load, scramble inputs during BUSY, wait for valid,
    // hold start 'hold' extra cycles, then drop start for one cycle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [63:0] exp;
        int          n;
        int          extra;
        logic        seen;
        exp = ref_prod(a, b);
        @(negedge clock);
        mlier = a;
        mcand = b;
        start = 1'b1;
        @(posedge clock);
        #1;
        mlier = $urandom;
        mcand = $urandom;
        n     = 0;
        seen  = 1'b0;
        while (!seen && n < 100) begin
            @(posedge clock);
            #1;
            n++;
            seen = valid;
        end
        check("valid_seen", 64'(seen), 64'd1);
        check("latency", 64'(n), 64'(ref_lat(a)));
        check("prodt", prodt, exp);
        extra = 0;
        for (int i = 0; i < hold + 1; i++) begin
            @(posedge clock);
            #1;
            if (valid) extra++;
        end
        check("single_valid", 64'(extra), 64'd0);
        check("prodt_hold", prodt, exp);
        @(negedge clock);
        start = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        reset = 1'b0;
        start = 1'b0;
        mlier = '0;
        mcand = '0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_valid", 64'(valid), 64'd0);
        check("reset_prodt", prodt, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Directed cases from the operation/boundary rules.
        do_op(32'h00000004, 32'h000fffff, 0);
        check("const_a", ref_prod(32'h00000004, 32'h000fffff), 64'h00000000003ffffc);
        do_op(32'hfffffffe, 32'h8fffffee, 0);
        do_op(32'h00000001, 32'hffffffff, 0);
        do_op(32'h80000000, 32'h80000000, 0);
        do_op(32'h00000000, 32'h7fffffff, 0);
        do_op(32'h7fffffff, 32'h80000000, 0);
        // Hold start well past valid: still exactly one pulse, then rearm.
        do_op(32'h00001234, 32'hffff0001, 10);
        do_op(32'hdeadbeef, 32'h12345678, 0);

        // Reset in the middle of a long operation.
        @(negedge clock);
        mlier = 32'h7fffffff;
        mcand = 32'h00000003;
        start = 1'b1;
        @(posedge clock);
        repeat (10) @(posedge clock);
        #1;
        check("busy_no_valid", 64'(valid), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clock);
        #1;
        check("midrst_valid", 64'(valid), 64'd0);
        check("midrst_prodt", prodt, 64'd0);
        repeat (40) @(posedge clock);
        #1;
        check("midrst_quiet", 64'(valid), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        do_op(32'hffffff00, 32'h00000005, 0);

        // Random traffic, some with short multipliers to vary latency.
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 0) a = 32'($urandom_range(0, 300));
            if (i % 5 == 1) a = -32'($urandom_range(0, 70000));
            do_op(a, b, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multi.md
# multi

Sequential signed 32×32 multiplier that returns a 64-bit two's-complement product under a start/valid handshake. It is used wherever area matters more than throughput. It is an iterative radix-2 shift-add datapath with one operation in flight. A compile-time macro selects fixed 32-iteration latency or data-dependent early termination.

## Interface
- No parameters.
- clock  input  1  rising-edge clock for all state
- reset  input  1  synchronous, active-low (0 = reset, sampled on clock rising edge)
- mlier  input  32  multiplier, signed two's complement
- mcand  input  32  multiplicand, signed two's complement
- prodt  output  64  signed product, registered, held until next result or reset
- start  input  1  request; level-sampled, held high by the requester until valid seen
- valid  output  1  one-cycle pulse, prodt is the new result while high

## Operation
- Result: prodt = signed(mlier) × signed(mcand), exact in 64 bits. Zero product is 0 with no negative zero. 0x80000000 × 0x80000000 = 64'h4000000000000000.
- Datapath is sign-magnitude:
  - Load |mlier| and |mcand| as 32-bit unsigned. 0x80000000 gives magnitude 2^31.
  - Record sign = mlier[31] ^ mcand[31].
  - Each iteration adds the shifted mcand magnitude when the current multiplier bit is 1, then shifts.
  - The final step two's-complement negates the 64-bit magnitude if sign = 1.
- FSM states:
  - IDLE: start=1 loads operands and goes to BUSY.
  - BUSY: performs one iteration per cycle. After the last iteration it writes prodt, pulses valid, and goes to DONE.
  - DONE: goes to IDLE when start=0. While start stays 1 it remains in DONE with no new operation and no second valid.
- Operands are sampled only on the load edge. Changes to mlier/mcand or deassertion of start during BUSY are ignored, and the operation completes.
- Reset (reset=0 at an edge), in any state including mid-operation: state=IDLE, valid=0, prodt=0, internal registers cleared. The partial result is discarded.

## Timing
- Load edge L is the first edge in IDLE with start=1. Iterations occur on edges L+1 … L+K.
- At edge L+K, prodt is written and valid rises. valid is high for exactly one cycle and falls at edge L+K+1.
- Fixed mode: K = 32, so valid is high in the 33rd cycle counted from the load edge. The requester holding start for 33 cycles sees valid within its start window.
- Variable mode: K = max(1, bit-length of |mlier|). The loop ends once the remaining multiplier magnitude is zero. Range is 1..32.
  - mlier=0 → K=1.
  - mlier=4 → K=3.
- Minimum back-to-back spacing: start must drop for at least one cycle (DONE→IDLE) before the next load.
- prodt is stable outside the valid cycle, holding the last result.

## Configuration
- MULTI_VAR_LATENCY_EN defined: variable-latency early termination as above.
- MULTI_VAR_LATENCY_EN undefined: fixed K = 32 for all operands.
- Results are bit-identical in both modes; only the latency differs.

## Test plan
- mlier=32'h00000004, mcand=32'h000fffff, start held → prodt=64'h00000000003ffffc. valid at L+32 in fixed mode, L+3 in variable mode.
- mlier=32'hfffffffe, mcand=32'h8fffffee → prodt=64'h00000000e0000024 (−2 × −0x70000012).
- mlier=32'h00000001, mcand=32'hffffffff → prodt=64'hffffffffffffffff. mlier=32'h80000000, mcand=32'h80000000 → 64'h4000000000000000.
- mlier=0, mcand=32'h7fffffff → prodt=0, no sign artifact. Variable mode valid at L+1.
- Hold start high 10 cycles past valid → exactly one valid pulse. Drop start 1 cycle, raise with new operands → new result with the same latency.
- Assert reset low 10 cycles into BUSY → next cycle valid=0, prodt=0, state IDLE. A subsequent start produces a correct product with no stale data.
